// File: rtl/tt_um_yavar_counter_if.sv
// Pin bundle of the TinyTapeout user frame, minus clk/rst_n.
// master drives ui/uio/ena, slave drives uo/uio_out/uio_oe.
interface tt_um_yavar_counter_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_yavar_counter.sv
// 4-bit up/down counter tile: load, clear, modulus limit, prescaler.
// Ports: clk, rst_n, ena, ui_in, uo_out, uio_in, uio_out, uio_oe.
module counter_stage (
  input  logic clk,
  input  logic rst_n,
  tt_um_yavar_counter_if.slave pins
);

  logic       cen;
  logic       dir;
  logic       ld;
  logic       clr;
  logic [3:0] lval;
  logic [3:0] lim;
  logic [3:0] ps;

  assign cen  = pins.ui_in[0];
  assign dir  = pins.ui_in[1];
  assign ld   = pins.ui_in[2];
  assign clr  = pins.ui_in[3];
  assign lval = pins.ui_in[7:4];
  assign lim  = pins.uio_in[3:0];
  assign ps   = pins.uio_in[7:4];

  logic [3:0] count;
  logic [3:0] count_nx;
  logic [3:0] pre;
  logic [3:0] pre_nx;
  logic       tc;
  logic       tc_nx;

  logic [3:0] step_cnt;
  logic       step_tc;

  // Step result if the prescaler lets this edge through.
  always_comb begin
    step_cnt = count;
    step_tc  = 1'b0;
    if (!dir) begin
      if (count >= lim) begin
        step_cnt = 4'd0;
        step_tc  = 1'b1;
      end else begin
        step_cnt = count + 4'd1;
      end
    end else begin
      if (count == 4'd0) begin
        step_cnt = lim;
        step_tc  = 1'b1;
      end else begin
        step_cnt = count - 4'd1;
      end
    end
  end

  // Clear > load > count > hold; all frozen while ena is low.
  // pre wraps naturally at 15->0 when P was lowered below it.
  always_comb begin
    count_nx = count;
    pre_nx   = pre;
    tc_nx    = tc;
    if (pins.ena) begin
      if (clr) begin
        count_nx = 4'd0;
        pre_nx   = 4'd0;
        tc_nx    = 1'b0;
      end else if (ld) begin
        count_nx = lval;
        pre_nx   = 4'd0;
        tc_nx    = 1'b0;
      end else if (cen) begin
        if (pre == ps) begin
          pre_nx   = 4'd0;
          count_nx = step_cnt;
          tc_nx    = step_tc;
        end else begin
          pre_nx = pre + 4'd1;
          tc_nx  = 1'b0;
        end
      end else begin
        tc_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
      pre   <= 4'd0;
      tc    <= 1'b0;
    end else begin
      count <= count_nx;
      pre   <= pre_nx;
      tc    <= tc_nx;
    end
  end

  logic run;
  assign run = pins.ena & cen & ~ld & ~clr;

  assign pins.uo_out = {
    run,
    (count == 4'd0),
    dir,
    tc,
    count
  };

  assign pins.uio_out = 8'h00;
  assign pins.uio_oe  = 8'h00;

endmodule

module tt_um_yavar_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  tt_um_yavar_counter_if pins ();

  assign pins.ena    = ena;
  assign pins.ui_in  = ui_in;
  assign pins.uio_in = uio_in;
  assign uo_out      = pins.uo_out;
  assign uio_out     = pins.uio_out;
  assign uio_oe      = pins.uio_oe;

  counter_stage u_stage (
    .clk   (clk),
    .rst_n (rst_n),
    .pins  (pins.slave)
  );

endmodule

// File: tb/tb_tt_um_yavar_counter.sv
// Directed bench for tt_um_yavar_counter.
// Drives the pin bundle, checks uo/uio with immediate assertions.
module tb_tt_um_yavar_counter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  tt_um_yavar_counter_if bus ();

  tt_um_yavar_counter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (bus.ena),
    .ui_in   (bus.ui_in),
    .uo_out  (bus.uo_out),
    .uio_in  (bus.uio_in),
    .uio_out (bus.uio_out),
    .uio_oe  (bus.uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_uio(input string tag);
    chk({tag, "_oe"}, bus.uio_oe, 8'h00);
    chk({tag, "_out"}, bus.uio_out, 8'h00);
  endtask

  initial begin
    logic [3:0] dn_val [7];
    logic       dn_tc  [7];
    logic [3:0] ps_val [7];
    logic [3:0] c;
    logic       t;
    n_chk  = 0;
    n_fail = 0;

    // Reset
    rst_n      = 1'b0;
    bus.ena    = 1'b0;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    #3;
    chk("reset", bus.uo_out, 8'h40);
    chk_uio("reset");
    tick();
    chk("reset_hold", bus.uo_out, 8'h40);

    // Up count, L=15, P=0
    rst_n      = 1'b1;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h01;
    bus.uio_in = 8'h0F;
    #1;
    chk("up_start", bus.uo_out, 8'hC0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      c = 4'(k % 16);
      t = (k == 16);
      chk($sformatf("up_%0d", k), bus.uo_out,
          {1'b1, (c == 4'd0), 1'b0, t, c});
    end
    bus.ui_in = 8'h00;
    tick();
    chk("up_idle_tc_drop", bus.uo_out, 8'h40);

    // Down count, L=5
    dn_val = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5};
    dn_tc  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.ui_in  = 8'h03;
    bus.uio_in = 8'h05;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("dn_%0d", k), bus.uo_out,
          {1'b1, (dn_val[k] == 4'd0), 1'b1, dn_tc[k], dn_val[k]});
    end

    // Load / clear priority
    bus.ui_in = 8'hA4;
    tick();
    chk("load_10", bus.uo_out, 8'h0A);
    bus.ui_in = 8'hAC;
    tick();
    chk("clr_beats_load", bus.uo_out, 8'h40);
    bus.uio_in = 8'h05;
    bus.ui_in  = 8'hA4;
    tick();
    chk("load_above_L", bus.uo_out, 8'h0A);
    bus.ui_in = 8'h01;
    tick();
    chk("above_L_wrap", bus.uo_out, 8'hD0);

    // L=0 boundary
    bus.uio_in = 8'h00;
    tick();
    chk("L0_up", bus.uo_out, 8'hD0);
    bus.ui_in = 8'h03;
    tick();
    chk("L0_down", bus.uo_out, 8'hF0);

    // Prescaler P=2
    bus.ui_in = 8'h08;
    tick();
    chk("ps_clr", bus.uo_out, 8'h40);
    bus.uio_in = 8'h2F;
    bus.ui_in  = 8'h01;
    ps_val = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
    #1;
    chk("ps_0", bus.uo_out, 8'hC0);
    for (int k = 1; k < 7; k++) begin
      tick();
      chk($sformatf("ps_%0d", k), bus.uo_out,
          {1'b1, (ps_val[k] == 4'd0), 2'b00, ps_val[k]});
    end

    // ena gating (count=2, pre=0)
    bus.ena = 1'b0;
    #1;
    chk("gate_run_low", bus.uo_out, 8'h02);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("gate_hold_%0d", k), bus.uo_out, 8'h02);
    end
    bus.ena = 1'b1;
    tick();
    chk("resume_0", bus.uo_out, 8'h82);
    tick();
    chk("resume_1", bus.uo_out, 8'h82);
    tick();
    chk("resume_2", bus.uo_out, 8'h83);

    // Async reset mid-count at 7
    bus.uio_in = 8'h0F;
    for (int k = 0; k < 4; k++) tick();
    chk("at_7", bus.uo_out, 8'h87);
    chk_uio("mid");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", bus.uo_out, 8'hC0);
    tick();
    chk("rst_held", bus.uo_out, 8'hC0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst", bus.uo_out, 8'h81);
    chk_uio("end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
